// File: rtl/bo_bing_pkg.sv
// ---------------------------------------------------------------------------
// bo_bing_pkg
// Shared types and constants for the Bo Bing dice scorer.
//   face_t   : 3-bit die face encoding (1..6 legal, 0 and 7 illegal)
//   count_t  : 3-bit per-face count (0..6 for six dice)
//   tier_e   : prize tier chosen by the decoder (TIER_NONE or P1..P6)
//   is_legal_face() : true for faces FACE_MIN..FACE_MAX
//   tier_onehot()   : tier -> {P1,P2,P3,P4,P5,P6} one-hot vector
// ---------------------------------------------------------------------------
package bo_bing_pkg;

  typedef logic [2:0] face_t;
  typedef logic [2:0] count_t;

  localparam face_t FACE_MIN = 3'd1;
  localparam face_t FACE_MAX = 3'd6;

  typedef enum logic [2:0] {
    TIER_NONE = 3'd0,
    TIER_P1   = 3'd1,
    TIER_P2   = 3'd2,
    TIER_P3   = 3'd3,
    TIER_P4   = 3'd4,
    TIER_P5   = 3'd5,
    TIER_P6   = 3'd6
  } tier_e;

  function automatic logic is_legal_face(input face_t f);
    return (f >= FACE_MIN) && (f <= FACE_MAX);
  endfunction

  // Bit 5 is P1 (highest tier), bit 0 is P6.
  function automatic logic [5:0] tier_onehot(input tier_e t);
    logic [5:0] v;
    case (t)
      TIER_P1: v = 6'b100000;
      TIER_P2: v = 6'b010000;
      TIER_P3: v = 6'b001000;
      TIER_P4: v = 6'b000100;
      TIER_P5: v = 6'b000010;
      TIER_P6: v = 6'b000001;
      default: v = 6'b000000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/bo_bing_face_counter.sv
// ---------------------------------------------------------------------------
// bo_bing_face_counter
// Combinational histogram of six dice.
//   D1..D6  in  : die faces (face_t)
//   c1..c6  out : number of dice showing each face (count_t)
//   illegal out : at least one die carries encoding 0 or 7
// Illegal dice are simply not counted; the scorer ignores the counts
// whenever illegal is set.
// ---------------------------------------------------------------------------
module bo_bing_face_counter
  import bo_bing_pkg::*;
(
  input  face_t  D1,
  input  face_t  D2,
  input  face_t  D3,
  input  face_t  D4,
  input  face_t  D5,
  input  face_t  D6,
  output count_t c1,
  output count_t c2,
  output count_t c3,
  output count_t c4,
  output count_t c5,
  output count_t c6,
  output logic   illegal
);

  face_t  dice_s [0:5];
  count_t cnt_s  [1:6];

  assign dice_s[0] = D1;
  assign dice_s[1] = D2;
  assign dice_s[2] = D3;
  assign dice_s[3] = D4;
  assign dice_s[4] = D5;
  assign dice_s[5] = D6;

  // Histogram the dice and flag any out-of-range encoding.
  always_comb begin
    illegal = 1'b0;
    for (int f = 1; f <= 6; f++) begin
      cnt_s[f] = 3'd0;
    end
    for (int j = 0; j < 6; j++) begin
      if (is_legal_face(dice_s[j])) begin
        for (int f = 1; f <= 6; f++) begin
          if (dice_s[j] == face_t'(f)) begin
            cnt_s[f] = cnt_s[f] + 3'd1;
          end else begin
            cnt_s[f] = cnt_s[f];
          end
        end
      end else begin
        illegal = 1'b1;
      end
    end
  end

  assign c1 = cnt_s[1];
  assign c2 = cnt_s[2];
  assign c3 = cnt_s[3];
  assign c4 = cnt_s[4];
  assign c5 = cnt_s[5];
  assign c6 = cnt_s[6];

endmodule

// File: rtl/bo_bing_scoring.sv
// ---------------------------------------------------------------------------
// bo_bing_scoring
// Scores one six-dice throw per valid_in cycle; results are registered and
// appear one cycle later together with a one-cycle valid_out pulse.
//   LUCKY_FACE      param : face used by the red prize rules (1..6)
//   clk, rst        in    : clock, asynchronous active-high reset
//   valid_in        in    : D1..D6 hold a new throw this cycle
//   D1..D6          in    : die faces (1..6 legal)
//   valid_out       out   : new result on P1..P6/err this cycle
//   P1..P6          out   : prize tier flags, P1 highest, at most one set
//   err             out   : last scored throw had an illegal face
// Results hold between throws; only valid_out drops back to 0.
// ---------------------------------------------------------------------------
module bo_bing_scoring
  import bo_bing_pkg::*;
#(
  parameter int LUCKY_FACE = 4
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  valid_in,
  input  face_t D1,
  input  face_t D2,
  input  face_t D3,
  input  face_t D4,
  input  face_t D5,
  input  face_t D6,
  output logic  valid_out,
  output logic  P1,
  output logic  P2,
  output logic  P3,
  output logic  P4,
  output logic  P5,
  output logic  P6,
  output logic  err
);

  count_t     cnt_s [1:6];
  logic       illegal_s;
  count_t     lucky_cnt_s;
  logic       any_five_s;
  logic       nonlucky_four_s;
  logic [2:0] triple_cnt_s;
  logic       straight_s;
  tier_e      tier_s;
  logic [5:0] prize_s;

  logic       valid_r;
  logic       err_r;
  logic [5:0] prize_r;

  bo_bing_face_counter u_counter (
    .D1      (D1),
    .D2      (D2),
    .D3      (D3),
    .D4      (D4),
    .D5      (D5),
    .D6      (D6),
    .c1      (cnt_s[1]),
    .c2      (cnt_s[2]),
    .c3      (cnt_s[3]),
    .c4      (cnt_s[4]),
    .c5      (cnt_s[5]),
    .c6      (cnt_s[6]),
    .illegal (illegal_s)
  );

  // Derive the pattern features used by the tier rules.
  always_comb begin
    lucky_cnt_s     = cnt_s[LUCKY_FACE];
    any_five_s      = 1'b0;
    nonlucky_four_s = 1'b0;
    triple_cnt_s    = 3'd0;
    straight_s      = 1'b1;
    for (int f = 1; f <= 6; f++) begin
      if (cnt_s[f] >= 3'd5) begin
        any_five_s = 1'b1;
      end else begin
        any_five_s = any_five_s;
      end
      if ((f != LUCKY_FACE) && (cnt_s[f] == 3'd4)) begin
        nonlucky_four_s = 1'b1;
      end else begin
        nonlucky_four_s = nonlucky_four_s;
      end
      if (cnt_s[f] == 3'd3) begin
        triple_cnt_s = triple_cnt_s + 3'd1;
      end else begin
        triple_cnt_s = triple_cnt_s;
      end
      if (cnt_s[f] != 3'd1) begin
        straight_s = 1'b0;
      end else begin
        straight_s = straight_s;
      end
    end
  end

  // Priority tier decode; the if-chain order is the tier priority.
  always_comb begin
    tier_s = TIER_NONE;
    if (illegal_s) begin
      tier_s = TIER_NONE;
    end else if ((lucky_cnt_s >= 3'd4) || any_five_s) begin
      tier_s = TIER_P1;
    end else if (straight_s) begin
      tier_s = TIER_P2;
    end else if (lucky_cnt_s == 3'd3) begin
      tier_s = TIER_P3;
    end else if (nonlucky_four_s || (triple_cnt_s == 3'd2)) begin
      tier_s = TIER_P4;
    end else if (lucky_cnt_s == 3'd2) begin
      tier_s = TIER_P5;
    end else if (lucky_cnt_s == 3'd1) begin
      tier_s = TIER_P6;
    end else begin
      tier_s = TIER_NONE;
    end
  end

  assign prize_s = tier_onehot(tier_s);

  // Output register: capture a result only on valid_in, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      prize_r <= 6'b000000;
    end else begin
      valid_r <= valid_in;
      if (valid_in) begin
        err_r   <= illegal_s;
        prize_r <= prize_s;
      end else begin
        err_r   <= err_r;
        prize_r <= prize_r;
      end
    end
  end

  assign valid_out = valid_r;
  assign err       = err_r;
  assign P1        = prize_r[5];
  assign P2        = prize_r[4];
  assign P3        = prize_r[3];
  assign P4        = prize_r[2];
  assign P5        = prize_r[1];
  assign P6        = prize_r[0];

endmodule

// File: tb/tb_bo_bing_scoring.sv
// ---------------------------------------------------------------------------
// tb_bo_bing_scoring
// Directed bench for bo_bing_scoring with LUCKY_FACE=4. Each check compares
// the packed vector {valid_out, err, P1..P6} with a hand-computed value.
// ---------------------------------------------------------------------------
module tb_bo_bing_scoring;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [2:0] D1, D2, D3, D4, D5, D6;
  logic       valid_out;
  logic       P1, P2, P3, P4, P5, P6;
  logic       err;

  int checks;
  int failures;

  bo_bing_scoring #(.LUCKY_FACE(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .D1        (D1),
    .D2        (D2),
    .D3        (D3),
    .D4        (D4),
    .D5        (D5),
    .D6        (D6),
    .valid_out (valid_out),
    .P1        (P1),
    .P2        (P2),
    .P3        (P3),
    .P4        (P4),
    .P5        (P5),
    .P6        (P6),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare {valid_out, err, P1..P6} against the expected vector.
  task automatic check(input string tag, input logic [7:0] exp);
    logic [7:0] obs;
    obs = {valid_out, err, P1, P2, P3, P4, P5, P6};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Present a throw with valid_in=1 and sample just after the scoring edge.
  task automatic throw6(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                        input logic [2:0] d, input logic [2:0] e, input logic [2:0] f);
    @(negedge clk);
    D1 = a; D2 = b; D3 = c; D4 = d; D5 = e; D6 = f;
    valid_in = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Idle cycle with new (ignored) dice on the bus.
  task automatic idle6(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c,
                       input logic [2:0] d, input logic [2:0] e, input logic [2:0] f);
    @(negedge clk);
    D1 = a; D2 = b; D3 = c; D4 = d; D5 = e; D6 = f;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    valid_in = 1'b0;
    D1 = 3'd1; D2 = 3'd1; D3 = 3'd1; D4 = 3'd1; D5 = 3'd1; D6 = 3'd1;

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 8'b0_0_000000);
    @(negedge clk);
    rst = 1'b0;

    // Illegal faces, then hold with err still set.
    throw6(3'd4, 3'd4, 3'd1, 3'd7, 3'd7, 3'd0);
    check("illegal", 8'b1_1_000000);
    idle6(3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4);
    check("hold_err", 8'b0_1_000000);

    // Back-to-back scored throws (valid_in stays high between them).
    throw6(3'd4, 3'd4, 3'd4, 3'd4, 3'd1, 3'd6);
    check("four_lucky_p1", 8'b1_0_100000);
    throw6(3'd5, 3'd4, 3'd5, 3'd5, 3'd5, 3'd5);
    check("five_of_5_p1", 8'b1_0_100000);
    throw6(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6);
    check("straight_p2", 8'b1_0_010000);
    throw6(3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2);
    check("two_triples_p4", 8'b1_0_000100);
    throw6(3'd4, 3'd1, 3'd4, 3'd6, 3'd3, 3'd4);
    check("three_lucky_p3", 8'b1_0_001000);
    throw6(3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2);
    check("four_nonlucky_p4", 8'b1_0_000100);
    throw6(3'd4, 3'd4, 3'd6, 3'd5, 3'd2, 3'd1);
    check("two_lucky_p5", 8'b1_0_000010);
    throw6(3'd6, 3'd1, 3'd5, 3'd6, 3'd3, 3'd5);
    check("no_prize", 8'b1_0_000000);
    throw6(3'd6, 3'd1, 3'd1, 3'd4, 3'd3, 3'd2);
    check("one_lucky_p6", 8'b1_0_000001);

    // Hold: dice change while valid_in=0.
    idle6(3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4);
    check("hold_p6_a", 8'b0_0_000001);
    idle6(3'd0, 3'd7, 3'd0, 3'd7, 3'd0, 3'd7);
    check("hold_p6_b", 8'b0_0_000001);

    // Boundary patterns.
    throw6(3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4);
    check("six_lucky_p1", 8'b1_0_100000);
    throw6(3'd4, 3'd4, 3'd2, 3'd4, 3'd4, 3'd4);
    check("five_lucky_p1", 8'b1_0_100000);
    throw6(3'd4, 3'd4, 3'd4, 3'd1, 3'd1, 3'd1);
    check("three_lucky_triple_p3", 8'b1_0_001000);
    throw6(3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4);
    check("four_nonlucky_two_lucky_p4", 8'b1_0_000100);
    throw6(3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3);
    check("six_of_3_p1", 8'b1_0_100000);

    // Asynchronous reset mid-stream, away from any clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("async_reset", 8'b0_0_000000);
    @(negedge clk);
    rst = 1'b0;

    // Throw whose result edge coincides with reset assertion is discarded.
    throw6(3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6);
    check("straight_before_reset", 8'b1_0_010000);
    @(negedge clk);
    D1 = 3'd4; D2 = 3'd4; D3 = 3'd4; D4 = 3'd4; D5 = 3'd4; D6 = 3'd4;
    valid_in = 1'b1;
    @(posedge clk);
    rst = 1'b1;
    #1;
    check("reset_at_edge", 8'b0_0_000000);
    @(negedge clk);
    rst = 1'b0;
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check("no_stale_after_reset", 8'b0_0_000000);

    // Fresh throw after reset scores normally.
    throw6(3'd6, 3'd4, 3'd1, 3'd2, 3'd3, 3'd5);
    check("straight_after_reset", 8'b1_0_010000);
    idle6(3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1);
    check("valid_pulse_ends", 8'b0_0_010000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bo_bing_scoring.md
BO_BING_SCORING -- requirements
Module: bo_bing_scoring

Interface
REQ-001 Parameter: LUCKY_FACE, default 4, face value used for the "4-faced" (red) prize rules; legal range 1..6.
REQ-002 Port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: valid_in  input  1  qualifies D1..D6 as a new throw this cycle.
REQ-005 Port: D1..D6  input  3 each  die faces; legal encodings 3'b001..3'b110 (faces 1..6).
REQ-006 Port: valid_out  output  1  one-cycle pulse marking a new result on P1..P6 and err.
REQ-007 Port: P1..P6  output  1 each  prize tier flags; P1 is the highest tier.
REQ-008 Port: err  output  1  last scored throw contained an illegal face (0 or 7).

Function
REQ-009 Each valid_in=1 cycle scores the throw; registered results appear after that edge (latency 1); valid_out=1 for exactly that following cycle.
REQ-010 When valid_in=0: P1..P6 and err hold their previous values; valid_out=0.
REQ-011 Any die equal to 0 or 7: err=1, P1..P6 all 0.
REQ-012 Legal throw: err=0; form six 3-bit face counts c1..c6 (each 0..6, sum 6).
REQ-013 P1 when c[LUCKY_FACE]>=4, or any face count >=5.
REQ-014 P2 when c1..c6 all equal 1 (straight).
REQ-015 P3 when c[LUCKY_FACE]==3.
REQ-016 P4 when any non-lucky face count ==4, or two distinct faces each have count 3.
REQ-017 P5 when c[LUCKY_FACE]==2.
REQ-018 P6 when c[LUCKY_FACE]==1.
REQ-019 Priority P1>P2>P3>P4>P5>P6: at most one P output high; lower tiers are suppressed when a higher tier matches.
REQ-020 No condition matched (legal throw): P1..P6 all 0, err=0.
REQ-021 Boundaries: six lucky faces, P1; five lucky faces, P1; a straight, P2 and not P6; three lucky faces plus a triple of another face, P3; four of a non-lucky face plus two lucky faces, P4.
REQ-022 Back-to-back valid_in cycles score every throw independently, with no carry-over between throws.

Reset
REQ-023 While rst=1: P1..P6=0, err=0, valid_out=0, asynchronously and irrespective of clk.
REQ-024 A throw whose result edge coincides with rst assertion is discarded; the first result after reset needs a fresh valid_in.

Structure
REQ-025 A shared package bo_bing_pkg holds the face constants (FACE_MIN=1, FACE_MAX=6), the die face type (3 bits) and the count type (3 bits).
REQ-026 One sub-module, bo_bing_face_counter, is combinational: D1..D6 in, c1..c6 and illegal flag out.
REQ-027 The tier decode is combinational in the top level and feeds a single output register stage.

Verification
REQ-028 Illegal: D=4,4,1,7,7,0 with valid_in -> err=1, P1..P6=000000, valid_out pulse.
REQ-029 Top tier: D=4,4,4,4,1,6 -> P1=1; D=5,4,5,5,5,5 -> P1=1; all other P=0.
REQ-030 Straight and triples: D=1,2,3,4,5,6 -> P2=1 only; D=1,1,1,2,2,2 -> P4=1 only.
REQ-031 Lucky counts: D=4,1,4,6,3,4 -> P3; D=1,1,1,1,2,2 -> P4; D=4,4,6,5,2,1 -> P5; D=6,1,1,4,3,2 -> P6; D=6,1,5,6,3,5 -> all 0.
REQ-032 Hold and reset: valid_in=0 with changing D -> outputs unchanged and valid_out=0; rst asserted mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
